// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a multicycle RV32I datapath with shared memory
// and a single ALU. It sequences fetch, decode, execute, memory and writeback,
// one instruction at a time.
// Configuration macro: MC_ILLEGAL_TRAP_EN. When defined, an illegal opcode raises
// trap and locks up until reset. When undefined, trap stays 0 and the illegal
// instruction is skipped.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        adrsrc,
  output logic        irwrite,
  output logic        pcupdate,
  output logic        regwrite,
  output logic [1:0]  alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  aluop,
  output logic [1:0]  resultsrc,
  output logic [3:0]  state,
  output logic        trap
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_R  = 4'd3,
    S_EXEC_I  = 4'd4,
    S_LUI     = 4'd5,
    S_ALUWB   = 4'd6,
    S_MEMADR  = 4'd7,
    S_MEMRD   = 4'd8,
    S_MEMWB   = 4'd9,
    S_MEMWR   = 4'd10,
    S_BRANCH  = 4'd11,
    S_JAL     = 4'd12,
    S_ILLEGAL = 4'd13
  } state_e;

  state_e state_q;
  state_e state_d;

  // Only the opcode, the load/store select bit and the BEQ/BNE select bit
  // steer this FSM; the remaining instruction fields belong to aludec.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31:13], instr[11:7]};

  assign state = state_q;

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Memory states hold until mem_ready.
  // Unused encodings 14 and 15 fall back to IDLE.
  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (instr[6:0])
          7'b0110011: state_d = S_EXEC_R;
          7'b0010011: state_d = S_EXEC_I;
          7'b0000011: state_d = S_MEMADR;
          7'b0100011: state_d = S_MEMADR;
          7'b1100011: state_d = S_BRANCH;
          7'b1101111: state_d = S_JAL;
          7'b0110111: state_d = S_LUI;
          default:    state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: state_d = S_ALUWB;
      S_EXEC_I: state_d = S_ALUWB;
      S_LUI:    state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_MEMADR: begin
        if (instr[5]) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMRD: begin
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_BRANCH: state_d = S_FETCH;
      S_JAL:    state_d = S_ALUWB;
`ifdef MC_ILLEGAL_TRAP_EN
      S_ILLEGAL: state_d = S_ILLEGAL;
`else
      S_ILLEGAL: state_d = S_FETCH;
`endif
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode. The outputs are Moore outputs of the state, except for
  // irwrite/pcupdate in FETCH (qualified by mem_ready) and pcupdate in BRANCH
  // (taken when zero differs from funct3[0], which covers BEQ and BNE).
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    adrsrc    = 1'b0;
    irwrite   = 1'b0;
    pcupdate  = 1'b0;
    regwrite  = 1'b0;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    aluop     = 2'b00;
    resultsrc = 2'b00;
    trap      = 1'b0;
    case (state_q)
      S_IDLE: begin
        mem_req = 1'b0;
      end
      S_FETCH: begin
        mem_req   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = mem_ready;
        pcupdate  = mem_ready;
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      S_EXEC_R: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
      end
      S_EXEC_I: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
      end
      S_LUI: begin
        alusrca = 2'b11;
        alusrcb = 2'b01;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adrsrc  = 1'b1;
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adrsrc  = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 2'b10;
        aluop    = 2'b01;
        pcupdate = zero ^ instr[12];
      end
      S_JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
      S_ILLEGAL: begin
`ifdef MC_ILLEGAL_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
      end
      default: begin
        trap = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. A directed stimulus process pushes the
// hand-derived expected output vector for each cycle into a queue. A separate
// monitor pops one vector on every falling edge and compares it with the DUT.
module tb_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] st;
    logic       req;
    logic       we;
    logic       adr;
    logic       irw;
    logic       pcu;
    logic       rw;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] op;
    logic [1:0] rs;
    logic       trap;
  } vec_t;

  localparam logic [3:0] IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, EXEC_R = 4'd3,
                         EXEC_I = 4'd4, LUI = 4'd5, ALUWB = 4'd6, MEMADR = 4'd7,
                         MEMRD = 4'd8, MEMWB = 4'd9, MEMWR = 4'd10, BRANCH = 4'd11,
                         JAL = 4'd12, ILLEGAL = 4'd13;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_LUI  = 32'h000001B7;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, adrsrc, irwrite, pcupdate, regwrite, trap;
  logic [1:0]  alusrca, alusrcb, aluop, resultsrc;
  logic [3:0]  state;

  vec_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  vec_t  act_s;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adrsrc(adrsrc), .irwrite(irwrite),
    .pcupdate(pcupdate), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .resultsrc(resultsrc), .state(state), .trap(trap)
  );

  always #5 clk = ~clk;

  assign act_s = {state, mem_req, mem_we, adrsrc, irwrite, pcupdate, regwrite,
                  alusrca, alusrcb, aluop, resultsrc, trap};

  // Hand-written table of the Moore outputs of each state; the Mealy
  // irwrite/pcupdate values are supplied by each directed step.
  function automatic vec_t moore(input logic [3:0] s);
    vec_t v;
    v = '0;
    v.st = s;
    case (s)
      FETCH:   begin v.req = 1'b1; v.sb = 2'b10; v.rs = 2'b10; end
      DECODE:  begin v.sa = 2'b01; v.sb = 2'b01; end
      EXEC_R:  begin v.sa = 2'b10; v.op = 2'b10; end
      EXEC_I:  begin v.sa = 2'b10; v.sb = 2'b01; v.op = 2'b10; end
      LUI:     begin v.sa = 2'b11; v.sb = 2'b01; end
      ALUWB:   begin v.rw = 1'b1; end
      MEMADR:  begin v.sa = 2'b10; v.sb = 2'b01; end
      MEMRD:   begin v.req = 1'b1; v.adr = 1'b1; end
      MEMWB:   begin v.rs = 2'b01; v.rw = 1'b1; end
      MEMWR:   begin v.req = 1'b1; v.we = 1'b1; v.adr = 1'b1; end
      BRANCH:  begin v.sa = 2'b10; v.op = 2'b01; end
      JAL:     begin v.sa = 2'b01; v.sb = 2'b10; end
`ifdef MC_ILLEGAL_TRAP_EN
      ILLEGAL: begin v.trap = 1'b1; end
`endif
      default: begin v.trap = 1'b0; end
    endcase
    return v;
  endfunction

  // One clock cycle: drive inputs, queue the expected outputs, advance.
  task automatic step(input string nm, input logic [31:0] ins, input logic mr,
                      input logic z, input logic rs, input logic [3:0] st,
                      input logic irw, input logic pcu);
    vec_t v;
    instr     = ins;
    mem_ready = mr;
    zero      = z;
    reset     = rs;
    v = moore(st);
    v.irw = irw;
    v.pcu = pcu;
    exp_q.push_back(v);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the DUT outputs against the next queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      vec_t e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act_s !== e) begin
        errors++;
        $display("FAIL %s: got st=%0d req=%b we=%b adr=%b irw=%b pcu=%b rw=%b sa=%b sb=%b op=%b rs=%b trap=%b ; expected st=%0d req=%b we=%b adr=%b irw=%b pcu=%b rw=%b sa=%b sb=%b op=%b rs=%b trap=%b",
                 n, act_s.st, act_s.req, act_s.we, act_s.adr, act_s.irw, act_s.pcu, act_s.rw,
                 act_s.sa, act_s.sb, act_s.op, act_s.rs, act_s.trap,
                 e.st, e.req, e.we, e.adr, e.irw, e.pcu, e.rw, e.sa, e.sb, e.op, e.rs, e.trap);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; instr = 32'h0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step("reset_idle", I_ADD, 1'b1, 1'b0, 1'b0, IDLE, 1'b0, 1'b0);

    // add x3,x1,x2: 0,1,2,3,6
    step("add_fetch",  I_ADD, 1'b1, 1'b0, 1'b0, FETCH,  1'b1, 1'b1);
    step("add_decode", I_ADD, 1'b1, 1'b0, 1'b0, DECODE, 1'b0, 1'b0);
    step("add_exec",   I_ADD, 1'b1, 1'b0, 1'b0, EXEC_R, 1'b0, 1'b0);
    step("add_wb",     I_ADD, 1'b1, 1'b0, 1'b0, ALUWB,  1'b0, 1'b0);

    // addi and lui
    step("addi_fetch", I_ADDI, 1'b1, 1'b0, 1'b0, FETCH,  1'b1, 1'b1);
    step("addi_dec",   I_ADDI, 1'b1, 1'b0, 1'b0, DECODE, 1'b0, 1'b0);
    step("addi_exec",  I_ADDI, 1'b1, 1'b0, 1'b0, EXEC_I, 1'b0, 1'b0);
    step("addi_wb",    I_ADDI, 1'b1, 1'b0, 1'b0, ALUWB,  1'b0, 1'b0);
    step("lui_fetch",  I_LUI,  1'b1, 1'b0, 1'b0, FETCH,  1'b1, 1'b1);
    step("lui_dec",    I_LUI,  1'b1, 1'b0, 1'b0, DECODE, 1'b0, 1'b0);
    step("lui_exec",   I_LUI,  1'b1, 1'b0, 1'b0, LUI,    1'b0, 1'b0);
    step("lui_wb",     I_LUI,  1'b1, 1'b0, 1'b0, ALUWB,  1'b0, 1'b0);

    // load with two wait states in FETCH and in MEMRD
    step("lw_fetch_w1", I_LW, 1'b0, 1'b0, 1'b0, FETCH,  1'b0, 1'b0);
    step("lw_fetch_w2", I_LW, 1'b0, 1'b0, 1'b0, FETCH,  1'b0, 1'b0);
    step("lw_fetch_ok", I_LW, 1'b1, 1'b0, 1'b0, FETCH,  1'b1, 1'b1);
    step("lw_decode",   I_LW, 1'b1, 1'b0, 1'b0, DECODE, 1'b0, 1'b0);
    step("lw_memadr",   I_LW, 1'b1, 1'b0, 1'b0, MEMADR, 1'b0, 1'b0);
    step("lw_memrd_w1", I_LW, 1'b0, 1'b0, 1'b0, MEMRD,  1'b0, 1'b0);
    step("lw_memrd_w2", I_LW, 1'b0, 1'b0, 1'b0, MEMRD,  1'b0, 1'b0);
    step("lw_memrd_ok", I_LW, 1'b1, 1'b0, 1'b0, MEMRD,  1'b0, 1'b0);
    step("lw_memwb",    I_LW, 1'b1, 1'b0, 1'b0, MEMWB,  1'b0, 1'b0);

    // store with one wait state
    step("sw_fetch",    I_SW, 1'b1, 1'b0, 1'b0, FETCH,  1'b1, 1'b1);
    step("sw_decode",   I_SW, 1'b1, 1'b0, 1'b0, DECODE, 1'b0, 1'b0);
    step("sw_memadr",   I_SW, 1'b1, 1'b0, 1'b0, MEMADR, 1'b0, 1'b0);
    step("sw_memwr_w1", I_SW, 1'b0, 1'b0, 1'b0, MEMWR,  1'b0, 1'b0);
    step("sw_memwr_ok", I_SW, 1'b1, 1'b0, 1'b0, MEMWR,  1'b0, 1'b0);

    // BEQ / BNE with both zero values
    step("beq_z1_fetch", I_BEQ, 1'b1, 1'b1, 1'b0, FETCH,  1'b1, 1'b1);
    step("beq_z1_dec",   I_BEQ, 1'b1, 1'b1, 1'b0, DECODE, 1'b0, 1'b0);
    step("beq_z1_br",    I_BEQ, 1'b1, 1'b1, 1'b0, BRANCH, 1'b0, 1'b1);
    step("beq_z0_fetch", I_BEQ, 1'b1, 1'b0, 1'b0, FETCH,  1'b1, 1'b1);
    step("beq_z0_dec",   I_BEQ, 1'b1, 1'b0, 1'b0, DECODE, 1'b0, 1'b0);
    step("beq_z0_br",    I_BEQ, 1'b1, 1'b0, 1'b0, BRANCH, 1'b0, 1'b0);
    step("bne_z1_fetch", I_BNE, 1'b1, 1'b1, 1'b0, FETCH,  1'b1, 1'b1);
    step("bne_z1_dec",   I_BNE, 1'b1, 1'b1, 1'b0, DECODE, 1'b0, 1'b0);
    step("bne_z1_br",    I_BNE, 1'b1, 1'b1, 1'b0, BRANCH, 1'b0, 1'b0);
    step("bne_z0_fetch", I_BNE, 1'b1, 1'b0, 1'b0, FETCH,  1'b1, 1'b1);
    step("bne_z0_dec",   I_BNE, 1'b1, 1'b0, 1'b0, DECODE, 1'b0, 1'b0);
    step("bne_z0_br",    I_BNE, 1'b1, 1'b0, 1'b0, BRANCH, 1'b0, 1'b1);

    // JAL
    step("jal_fetch", I_JAL, 1'b1, 1'b0, 1'b0, FETCH,  1'b1, 1'b1);
    step("jal_dec",   I_JAL, 1'b1, 1'b0, 1'b0, DECODE, 1'b0, 1'b0);
    step("jal_jal",   I_JAL, 1'b1, 1'b0, 1'b0, JAL,    1'b0, 1'b1);
    step("jal_wb",    I_JAL, 1'b1, 1'b0, 1'b0, ALUWB,  1'b0, 1'b0);

    // reset asserted in the middle of a read wait
    step("rst_fetch",  I_LW, 1'b1, 1'b0, 1'b0, FETCH,  1'b1, 1'b1);
    step("rst_dec",    I_LW, 1'b1, 1'b0, 1'b0, DECODE, 1'b0, 1'b0);
    step("rst_memadr", I_LW, 1'b1, 1'b0, 1'b0, MEMADR, 1'b0, 1'b0);
    step("rst_memrd",  I_LW, 1'b0, 1'b0, 1'b0, MEMRD,  1'b0, 1'b0);
    step("rst_memrd_rst", I_LW, 1'b1, 1'b0, 1'b1, MEMRD, 1'b0, 1'b0);
    step("rst_idle",   I_LW, 1'b1, 1'b0, 1'b0, IDLE,   1'b0, 1'b0);

    // illegal opcode
    step("bad_fetch", I_BAD, 1'b1, 1'b0, 1'b0, FETCH,   1'b1, 1'b1);
    step("bad_dec",   I_BAD, 1'b1, 1'b0, 1'b0, DECODE,  1'b0, 1'b0);
`ifdef MC_ILLEGAL_TRAP_EN
    step("bad_trap1", I_BAD, 1'b1, 1'b0, 1'b0, ILLEGAL, 1'b0, 1'b0);
    step("bad_trap2", I_ADD, 1'b1, 1'b0, 1'b0, ILLEGAL, 1'b0, 1'b0);
    step("bad_trap3", I_ADD, 1'b1, 1'b0, 1'b1, ILLEGAL, 1'b0, 1'b0);
    step("bad_idle",  I_ADD, 1'b1, 1'b0, 1'b0, IDLE,    1'b0, 1'b0);
`else
    step("bad_nop",   I_BAD, 1'b1, 1'b0, 1'b0, ILLEGAL, 1'b0, 1'b0);
    step("bad_next",  I_ADD, 1'b1, 1'b0, 1'b0, FETCH,   1'b1, 1'b1);
`endif

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
